// File: rtl/mem_lsu.sv
// mem_lsu: MEM-stage load/store unit in front of the dcache, returning in-order completions to WB
// through a credit-limited FIFO. Define LSU_PERF_CNT_EN to build the load/store/miss counters.
module mem_lsu #(
  parameter int DEPTH = 4,
  parameter int AW    = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_store,
  input  logic [2:0]    req_sz,
  input  logic          req_signed,
  input  logic [AW-1:0] req_addr,
  input  logic [31:0]   req_wdata,
  input  logic [4:0]    req_rd,
  output logic          dc_re,
  output logic [31:0]   dc_raddr,
  output logic          dc_we,
  output logic [31:0]   dc_waddr,
  output logic [31:0]   dc_wdata,
  output logic [2:0]    dc_wsz,
  input  logic [31:0]   dc_rdata,
  input  logic          dc_hit,
  output logic          wb_valid,
  input  logic          wb_ready,
  output logic [4:0]    wb_rd,
  output logic [31:0]   wb_data,
  output logic          wb_is_load,
  output logic          wb_ale,
  output logic          wb_miss,
  output logic [31:0]   perf_ld,
  output logic [31:0]   perf_st,
  output logic [31:0]   perf_miss
);
  localparam logic [2:0] ACCESS_SZ_BYTE = 3'd0;
  localparam logic [2:0] ACCESS_SZ_HALF = 3'd1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  typedef struct packed {
    logic       valid;
    logic       store;
    logic [2:0] sz;
    logic       sgn;
    logic [4:0] rd;
    logic       ale;
  } trk_t;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
    logic        is_load;
    logic        ale;
    logic        miss;
  } cpl_t;

  logic [CW-1:0] credits;
  logic [CW-1:0] count;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  cpl_t          fifo_mem [DEPTH];
  trk_t          s_in;
  trk_t          s1;
  trk_t          s2;
  cpl_t          cpl;
  cpl_t          head;
  logic [31:0]   ld_data;
  logic          acc;
  logic          pop;
  logic          push;
  logic          ale;
  logic          is_byte;
  logic          is_half;

  // Both handshakes transfer on a cycle where valid & ready are high; valid never depends on ready.
  // Every accept holds one credit until its completion is popped, so the FIFO can never overflow.
  assign req_ready = ~rst_n & (credits < CW'(DEPTH));
  assign acc       = req_valid & req_ready;
  assign is_byte   = (req_sz == ACCESS_SZ_BYTE);
  assign is_half   = (req_sz == ACCESS_SZ_HALF);
  assign ale       = is_half ? req_addr[0] : (~is_byte & (req_addr[1:0] != 2'b00));

  always_comb begin
    dc_re    = 1'b0;
    dc_raddr = '0;
    dc_we    = 1'b0;
    dc_waddr = '0;
    dc_wdata = '0;
    dc_wsz   = '0;
    if (acc && !ale && !req_store) begin
      dc_re    = 1'b1;
      dc_raddr = 32'(req_addr);
    end
    if (acc && !ale && req_store) begin
      dc_we    = 1'b1;
      dc_waddr = 32'(req_addr);
      dc_wsz   = req_sz;
      if (is_byte)      dc_wdata = {24'h0, req_wdata[7:0]};
      else if (is_half) dc_wdata = {16'h0, req_wdata[7:0], req_wdata[15:8]};
      else              dc_wdata = {req_wdata[7:0], req_wdata[15:8], req_wdata[23:16], req_wdata[31:24]};
    end
  end

  always_comb begin
    s_in       = '0;
    s_in.valid = acc;
    s_in.store = req_store;
    s_in.sz    = req_sz;
    s_in.sgn   = req_signed;
    s_in.rd    = req_rd;
    s_in.ale   = ale;
  end

  // Stage 2 lines up with the dcache's fixed two-cycle read return.
  always_comb begin
    case (s2.sz)
      ACCESS_SZ_BYTE: ld_data = {{24{s2.sgn & dc_rdata[7]}}, dc_rdata[7:0]};
      ACCESS_SZ_HALF: ld_data = {{16{s2.sgn & dc_rdata[15]}}, dc_rdata[15:0]};
      default:        ld_data = dc_rdata;
    endcase
    cpl         = '0;
    cpl.rd      = s2.rd;
    cpl.is_load = ~s2.store;
    cpl.ale     = s2.ale;
    cpl.miss    = ~s2.store & ~s2.ale & ~dc_hit;
    cpl.data    = (s2.store | s2.ale | cpl.miss) ? 32'h0 : ld_data;
  end

  assign push       = s2.valid;
  assign wb_valid   = (count != '0);
  assign pop        = wb_valid & wb_ready;
  assign head       = fifo_mem[rd_ptr];
  assign wb_rd      = head.rd;
  assign wb_data    = head.data;
  assign wb_is_load = head.is_load;
  assign wb_ale     = head.ale;
  assign wb_miss    = head.miss;

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      for (int i = 0; i < DEPTH; i++) fifo_mem[i] <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      credits <= '0;
      s1      <= '0;
      s2      <= '0;
    end else begin
      s1 <= s_in;
      s2 <= s1;
      if (push) begin
        fifo_mem[wr_ptr] <= cpl;
        wr_ptr           <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
      case ({acc, pop})
        2'b10:   credits <= credits + CW'(1);
        2'b01:   credits <= credits - CW'(1);
        default: ;
      endcase
    end
  end

`ifdef LSU_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      perf_ld   <= '0;
      perf_st   <= '0;
      perf_miss <= '0;
    end else begin
      if (acc && !req_store) perf_ld <= perf_ld + 32'd1;
      if (acc && req_store)  perf_st <= perf_st + 32'd1;
      if (push && cpl.miss)  perf_miss <= perf_miss + 32'd1;
    end
  end
`else
  assign perf_ld   = '0;
  assign perf_st   = '0;
  assign perf_miss = '0;
`endif
endmodule

// File: tb/tb_mem_lsu.sv
// tb_mem_lsu: randomized and directed bench for mem_lsu against a byte-array dcache and completion scoreboard.
`timescale 1ns/1ps
module tb_mem_lsu;
  localparam int DEPTH = 4;
  localparam int AW    = 32;
  localparam logic [2:0] SZ_B = 3'd0;
  localparam logic [2:0] SZ_H = 3'd1;
  localparam logic [2:0] SZ_W = 3'd2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid, req_ready, req_store, req_signed;
  logic [2:0]    req_sz;
  logic [AW-1:0] req_addr;
  logic [31:0]   req_wdata;
  logic [4:0]    req_rd;
  logic          dc_re, dc_we, dc_hit;
  logic [31:0]   dc_raddr, dc_waddr, dc_wdata, dc_rdata;
  logic [2:0]    dc_wsz;
  logic          wb_valid, wb_ready, wb_is_load, wb_ale, wb_miss;
  logic [4:0]    wb_rd;
  logic [31:0]   wb_data;
  logic [31:0]   perf_ld, perf_st, perf_miss;

  mem_lsu #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store), .req_sz(req_sz),
    .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
    .dc_re(dc_re), .dc_raddr(dc_raddr), .dc_we(dc_we), .dc_waddr(dc_waddr),
    .dc_wdata(dc_wdata), .dc_wsz(dc_wsz), .dc_rdata(dc_rdata), .dc_hit(dc_hit),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data),
    .wb_is_load(wb_is_load), .wb_ale(wb_ale), .wb_miss(wb_miss),
    .perf_ld(perf_ld), .perf_st(perf_st), .perf_miss(perf_miss)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // scoreboard and reference model state; entry = {rd, data, is_load, ale, miss}
  logic [39:0] exp_q[$];
  logic [7:0]  mem [int];
  logic [32:0] dq0, dq1;
  int          n_chk, n_fail, cyc, acc_cyc, credits_m, n_ld, n_st, n_miss, n_re;
  logic        mon_acc, mon_wb_valid, mon_req_ready, rand_ready_on;
  logic [39:0] last_wb;
  logic [31:0] last_dc_wdata;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic exp_ale(input logic [2:0] sz, input logic [31:0] a);
    if (sz == SZ_B) return 1'b0;
    if (sz == SZ_H) return (a % 2) != 0;
    return (a % 4) != 0;
  endfunction

  function automatic int nbytes(input logic [2:0] sz);
    if (sz == SZ_B) return 1;
    if (sz == SZ_H) return 2;
    return 4;
  endfunction

  function automatic logic [7:0] rd_byte(input int a);
    if (mem.exists(a)) return mem[a];
    return 8'((a * 37 + 5) & 255);
  endfunction

  // Called at each negedge: plays the dcache, checks the request side, pushes and pops expectations.
  task automatic observe();
    logic [39:0] e;
    logic [39:0] got;
    logic        ale_m, hit, miss, exp_re, exp_we;
    logic [31:0] w, v, exp_wd;
    int          a;
    cyc++;
    mon_wb_valid  = wb_valid;
    mon_req_ready = req_ready;
    mon_acc       = 1'b0;
    if (rst_n) begin
      check("rst_req_ready", 64'(req_ready), 64'(0));
      check("rst_wb_valid", 64'(wb_valid), 64'(0));
      exp_q.delete();
      credits_m = 0;
      n_ld = 0;
      n_st = 0;
      n_miss = 0;
      return;
    end
    dc_rdata = dq1[31:0];
    dc_hit   = dq1[32];
    dq1      = dq0;
    dq0      = {1'($urandom_range(0, 1)), 32'($urandom())};
    check("req_ready", 64'(req_ready), 64'(credits_m < DEPTH));

    if (wb_valid) begin
      check("wb_spurious", 64'(exp_q.size() != 0), 64'(1));
      if (wb_ready && exp_q.size() != 0) begin
        e   = exp_q.pop_front();
        got = {wb_rd, wb_data, wb_is_load, wb_ale, wb_miss};
        check("wb_entry", 64'(got), 64'(e));
        last_wb = got;
        credits_m--;
      end
    end

    a       = int'(req_addr);
    ale_m   = exp_ale(req_sz, 32'(req_addr));
    mon_acc = req_valid && req_ready;
    exp_re  = mon_acc && !req_store && !ale_m;
    exp_we  = mon_acc && req_store && !ale_m;
    exp_wd  = 32'h0;
    if (exp_we) begin
      if (req_sz == SZ_B) exp_wd = req_wdata & 32'hFF;
      else if (req_sz == SZ_H) exp_wd = ((req_wdata & 32'hFF) << 8) | ((req_wdata >> 8) & 32'hFF);
      else for (int i = 0; i < 4; i++) exp_wd |= ((req_wdata >> (8 * i)) & 32'hFF) << (8 * (3 - i));
    end
    check("dc_re", 64'(dc_re), 64'(exp_re));
    check("dc_raddr", 64'(dc_raddr), exp_re ? 64'(req_addr) : 64'(0));
    check("dc_we", 64'(dc_we), 64'(exp_we));
    check("dc_waddr", 64'(dc_waddr), exp_we ? 64'(req_addr) : 64'(0));
    check("dc_wdata", 64'(dc_wdata), 64'(exp_wd));
    check("dc_wsz", 64'(dc_wsz), exp_we ? 64'(req_sz) : 64'(0));
    if (dc_re) n_re++;

    if (mon_acc) begin
      acc_cyc = cyc;
      credits_m++;
      if (req_store) begin
        n_st++;
        last_dc_wdata = dc_wdata;
        if (!ale_m) for (int i = 0; i < nbytes(req_sz); i++) mem[a + i] = 8'((req_wdata >> (8 * i)) & 32'hFF);
        e = {req_rd, 32'h0, 1'b0, ale_m, 1'b0};
      end else begin
        n_ld++;
        w    = {rd_byte(a + 3), rd_byte(a + 2), rd_byte(a + 1), rd_byte(a)};
        hit  = (req_addr[14] == 1'b0);
        miss = !ale_m && !hit;
        if (!ale_m) dq0 = hit ? {1'b1, w} : {1'b0, 32'($urandom())};
        if (req_sz == SZ_B) begin
          v = w & 32'hFF;
          if (req_signed && v >= 128) v = v - 256;
        end else if (req_sz == SZ_H) begin
          v = w & 32'hFFFF;
          if (req_signed && v >= 32768) v = v - 65536;
        end else begin
          v = w;
        end
        if (ale_m || miss) v = 32'h0;
        if (miss) n_miss++;
        e = {req_rd, v, 1'b1, ale_m, miss};
      end
      exp_q.push_back(e);
    end
  endtask

  // driver tasks
  task automatic step();
    @(negedge clk);
    observe();
    @(posedge clk);
    #1;
    if (rand_ready_on) wb_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic send(input logic st, input logic [2:0] sz, input logic sg, input logic [31:0] a,
                      input logic [31:0] d, input logic [4:0] rd);
    logic done;
    done       = 1'b0;
    req_valid  = 1'b1;
    req_store  = st;
    req_sz     = sz;
    req_signed = sg;
    req_addr   = AW'(a);
    req_wdata  = d;
    req_rd     = rd;
    for (int i = 0; i < 100 && !done; i++) begin
      step();
      done = mon_acc;
    end
    check("send_accepted", 64'(done), 64'(1));
    req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int i;
    i = 0;
    while (exp_q.size() != 0 && i < 200) begin
      step();
      i++;
    end
    check("drain", 64'(exp_q.size()), 64'(0));
  endtask

  initial begin
    logic        st, sg, done;
    logic [2:0]  sz;
    logic [31:0] a, last_a, d;
    int          re0;
    n_chk = 0; n_fail = 0; cyc = 0; acc_cyc = 0; credits_m = 0;
    n_ld = 0; n_st = 0; n_miss = 0; n_re = 0;
    dq0 = '0; dq1 = '0; dc_rdata = '0; dc_hit = 1'b0;
    rand_ready_on = 1'b0; last_wb = '0; last_dc_wdata = '0; last_a = 32'h0;
    req_valid = 1'b0; req_store = 1'b0; req_sz = '0; req_signed = 1'b0;
    req_addr = '0; req_wdata = '0; req_rd = '0; wb_ready = 1'b1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    repeat (3) step();
    rst_n = 1'b0;
    step();
    check("init_wb_valid", 64'(mon_wb_valid), 64'(0));
    check("init_req_ready", 64'(mon_req_ready), 64'(1));
    check("init_perf_ld", 64'(perf_ld), 64'(0));

    // store word then load it back with the accept-to-completion latency
    send(1'b1, SZ_W, 1'b0, 32'h40, 32'h11223344, 5'd1);
    check("st_word_lanes", 64'(last_dc_wdata), 64'h44332211);
    wait_idle();
    send(1'b0, SZ_W, 1'b1, 32'h40, 32'h0, 5'd2);
    for (int i = 0; i < 10; i++) begin
      step();
      if (mon_wb_valid) break;
    end
    check("load_latency", 64'(cyc - acc_cyc), 64'(3));
    wait_idle();
    check("ldw_data", 64'(last_wb[34:3]), 64'h11223344);
    check("ldw_miss", 64'(last_wb[0]), 64'(0));

    // byte loads, signed and unsigned
    send(1'b1, SZ_B, 1'b0, 32'h41, 32'hABCD_00F0, 5'd3);
    send(1'b0, SZ_B, 1'b1, 32'h41, 32'h0, 5'd4);
    wait_idle();
    check("ldb_signed", 64'(last_wb[34:3]), 64'hFFFFFFF0);
    send(1'b0, SZ_B, 1'b0, 32'h41, 32'h0, 5'd5);
    wait_idle();
    check("ldb_unsigned", 64'(last_wb[34:3]), 64'h000000F0);

    // misaligned half: no dcache read, ale completion
    re0 = n_re;
    send(1'b0, SZ_H, 1'b0, 32'h43, 32'h0, 5'd6);
    wait_idle();
    check("ale_no_re", 64'(n_re - re0), 64'(0));
    check("ale_flag", 64'(last_wb[1]), 64'(1));
    check("ale_data", 64'(last_wb[34:3]), 64'(0));

    // miss
    send(1'b0, SZ_W, 1'b0, 32'h4000, 32'h0, 5'd7);
    wait_idle();
    check("miss_flag", 64'(last_wb[0]), 64'(1));
    check("miss_data", 64'(last_wb[34:3]), 64'(0));

    // credit back-pressure with WB stalled
    wb_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(1'b0, SZ_W, 1'b0, 32'(i * 4), 32'h0, 5'(10 + i));
    req_valid = 1'b1; req_store = 1'b0; req_sz = SZ_W; req_signed = 1'b0;
    req_addr = AW'(32'h10); req_rd = 5'd14;
    for (int i = 0; i < 4; i++) begin
      step();
      check("bp_ready_low", 64'(mon_req_ready), 64'(0));
    end
    wb_ready = 1'b1;
    step();
    check("bp_ready_at_pop", 64'(mon_req_ready), 64'(0));
    step();
    check("bp_ready_after_pop", 64'(mon_acc), 64'(1));
    done = mon_acc;
    for (int i = 0; i < 10 && !done; i++) begin
      step();
      done = mon_acc;
    end
    req_valid = 1'b0;
    wait_idle();

    // reset with two operations in flight
    send(1'b0, SZ_W, 1'b0, 32'h100, 32'h0, 5'd20);
    send(1'b0, SZ_B, 1'b1, 32'h101, 32'h0, 5'd21);
    rst_n = 1'b1;
    step();
    step();
    rst_n = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      check("post_rst_wb_valid", 64'(mon_wb_valid), 64'(0));
      check("post_rst_ready", 64'(mon_req_ready), 64'(1));
    end
    check("post_rst_perf_ld", 64'(perf_ld), 64'(0));
    check("post_rst_perf_st", 64'(perf_st), 64'(0));
    check("post_rst_perf_miss", 64'(perf_miss), 64'(0));

    // randomized traffic with random WB back-pressure
    rand_ready_on = 1'b1;
    for (int n = 0; n < 300; n++) begin
      st = 1'($urandom_range(0, 1));
      sg = 1'($urandom_range(0, 1));
      sz = 3'($urandom_range(0, 3));
      d  = $urandom();
      a  = 32'($urandom_range(0, 'h3FFF));
      if ($urandom_range(0, 3) == 0) a = a | 32'h4000;
      if ($urandom_range(0, 3) != 0) begin
        if (sz == SZ_H) a = a & ~32'h1;
        else if (sz != SZ_B) a = a & ~32'h3;
      end
      if ($urandom_range(0, 4) == 0) a = last_a;
      last_a = a;
      send(st, sz, sg, a, d, 5'($urandom_range(0, 31)));
      if ($urandom_range(0, 3) == 0) step();
    end
    rand_ready_on = 1'b0;
    wb_ready = 1'b1;
    wait_idle();
    step();

`ifdef LSU_PERF_CNT_EN
    check("perf_ld", 64'(perf_ld), 64'(n_ld));
    check("perf_st", 64'(perf_st), 64'(n_st));
    check("perf_miss", 64'(perf_miss), 64'(n_miss));
`else
    check("perf_ld", 64'(perf_ld), 64'(0));
    check("perf_st", 64'(perf_st), 64'(0));
    check("perf_miss", 64'(perf_miss), 64'(0));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_lsu.md
Name: mem_lsu

Overview:
Load/store unit in the MEM stage, directly upstream of the data cache (dcache).
- Accepts memory requests from EX over a valid/ready handshake and checks alignment.
- Drives the dcache read/write ports, tracks the fixed 2-cycle dcache read latency and sign/zero-extends load data.
- Returns in-order completions to WB through an output FIFO whose occupancy is credit-limited, so a response is never dropped.

Parameters:
DEPTH, 4, completion FIFO entries; also the max in-flight plus queued operations (power of two, >=2)
AW, 32, address width

Ports:
clk  in  1  clock; all state on posedge
rst_n  in  1  reset; asynchronous, active-high (1 = reset asserted)
req_valid  in  1  EX request valid
req_ready  out  1  LSU can accept
req_store  in  1  1 = store, 0 = load
req_sz  in  3  ACCESS_SZ_BYTE / ACCESS_SZ_HALF / other = word (defs.v encoding)
req_signed  in  1  load sign-extend
req_addr  in  AW  byte address
req_wdata  in  32  store data, little-endian value
req_rd  in  5  destination register tag
dc_re  out  1  dcache read enable
dc_raddr  out  32  dcache read address
dc_we  out  1  dcache write enable
dc_waddr  out  32  dcache write address
dc_wdata  out  32  dcache write data (dcache lane order)
dc_wsz  out  3  dcache access size
dc_rdata  in  32  dcache read data, valid 2 cycles after dc_re
dc_hit  in  1  dcache hit, same timing as dc_rdata
wb_valid  out  1  completion available
wb_ready  in  1  WB consumes completion
wb_rd  out  5  tag
wb_data  out  32  extended load data; 0 for stores
wb_is_load  out  1  completion is a load
wb_ale  out  1  misaligned access
wb_miss  out  1  load returned dc_hit = 0
perf_ld / perf_st / perf_miss  out  32 each  performance counters (see Optional Feature)

Behaviour:
Reset:
- Completion FIFO emptied; credit counter = 0; pipeline valids = 0.
- Outputs: wb_valid = 0, req_ready = 0 while reset is asserted, perf counters = 0.

Accept and issue:
- acc = req_valid & req_ready. req_ready = (credits < DEPTH).
- Misaligned: half with addr[0] = 1, or word with addr[1:0] != 0 -> ale = 1. No dcache access; the operation still occupies a credit and completes.
- Aligned load: dc_re = acc, combinational in the accept cycle; dc_raddr = req_addr.
- Aligned store: dc_we = acc; dc_waddr = req_addr; dc_wsz = req_sz.
- Store data is swapped into dcache lane order:
  - word: dc_wdata = {d[7:0], d[15:8], d[23:16], d[31:24]}
  - half: dc_wdata[15:0] = {d[7:0], d[15:8]}, upper bits 0
  - byte: dc_wdata[7:0] = d[7:0], upper bits 0
- All dc_* outputs are 0 when not enabled.

Tracking and completion:
- Two-stage shift register carries {valid, store, sz, signed, rd, ale}. Stage 2 aligns with dc_rdata/dc_hit.
- Load data (dc_rdata[7:0] is the byte at addr):
  - byte -> ext(rdata[7:0])
  - half -> ext(rdata[15:0])
  - word -> rdata
- wb_miss = is_load & ~ale & ~dc_hit; wb_data = 0 when ale or miss.
- Stage-2 entry is pushed into the FIFO at the next posedge. Accept-to-wb_valid latency with an empty FIFO = 3 cycles.
- FIFO outputs are registered, first-word-fall-through; pop when wb_valid & wb_ready.

Credits:
- +1 on acc, -1 on pop; simultaneous acc and pop -> unchanged.
- credits == DEPTH -> req_ready = 0. This guarantees FIFO never overflows since dcache cannot stall.
- Back-to-back accepts allowed every cycle. Order strictly preserved.

Store-to-load ordering: a load issued the cycle after a store to the same address relies on dcache write-buffer forwarding; the LSU inserts no bubble.

Reset mid-operation: in-flight and queued operations discarded; no wb_valid after release until new accepts.

Optional Feature:
LSU_PERF_CNT_EN:
- Defined: perf_ld / perf_st count accepted loads/stores; perf_miss counts wb_miss pushes. 32-bit, wrap at 2^32, cleared on reset.
- Undefined: counter logic absent, ports tied to 0.

Test Plan:
- Store word 0x11223344 @0x40, then load word signed @0x40 -> dc_wdata = 0x44332211; wb_data = 0x11223344, wb_miss = 0, wb_valid 3 cycles after accept.
- Load byte signed @0x41 with dc_rdata = 0x000000F0 -> wb_data = 0xFFFFFFF0; unsigned -> 0x000000F0.
- Load half @0x43 -> wb_ale = 1, dc_re never asserted, wb_data = 0.
- Load word @0x4000 with dc_hit = 0 -> wb_miss = 1, wb_data = 0.
- wb_ready = 0, 5 back-to-back requests with DEPTH = 4 -> req_ready drops after 4th accept. Raising wb_ready drains tags in order, and req_ready returns the cycle after the first pop.
- Reset pulse with 2 ops in flight -> wb_valid stays 0, credits = 0, perf counters = 0.
